vedic_mult16_seq: RTL and testbench

VEDIC_MULT16_SEQ -- requirements
Module: vedic_mult16_seq

---
 rtl/vedic_pkg.sv | 16 +
 rtl/vedic_mult_half.sv | 36 +++
 rtl/vedic_mult16_seq.sv | 136 +++++++++++++
 tb/tb_vedic_mult16_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Vedic 16x16 multiplier:
// FSM state encoding and the default operand width.
package vedic_pkg;

    localparam int VEDIC_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } vedic_state_e;

endpackage

// File: rtl/vedic_mult_half.sv
// Combinational HxH unsigned multiplier, Urdhva-Tiryagbhyam form:
// each product column k is the vertical/crosswise sum of x[i]&y[j]
// with i+j == k, and the column sums are weighted and added.
module vedic_mult_half
    import vedic_pkg::*;
#(
    parameter int H = VEDIC_WIDTH_DEF / 2
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-1:0] p
);

    localparam int CW = $clog2(H + 1);
    localparam int PW = 2 * H;

    logic [CW-1:0] col;

    // Crosswise column sums folded into the weighted product.
    always_comb begin
        p   = '0;
        col = '0;
        for (int k = 0; k < 2 * H - 1; k++) begin
            col = '0;
            for (int i = 0; i < H; i++) begin
                for (int j = 0; j < H; j++) begin
                    if (i + j == k) begin
                        col = col + CW'(x[i] & y[j]);
                    end
                end
            end
            p = p + (PW'(col) << k);
        end
    end

endmodule

// File: rtl/vedic_mult16_seq.sv
// Sequential N x N unsigned multiplier built from one shared HxH Vedic
// sub-multiplier, producing one partial product per cycle (P0..P3).
// Optional macro VEDIC_ZERO_BYPASS_EN: a zero operand skips P1..P3 and
// presents prod = 0 one edge after the accept.
//
// state | meaning
// IDLE  | ready for operands
// P0    | acc  = aL*bL
// P1    | acc += (aH*bL) << H
// P2    | acc += (aL*bH) << H
// P3    | acc += (aH*bH) << N
// DONE  | prod valid, waiting for out_ready
module vedic_mult16_seq
    import vedic_pkg::*;
#(
    parameter int N = VEDIC_WIDTH_DEF   // even, >= 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod
);

    localparam int H = N / 2;

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_P0   = P0;
    localparam logic [2:0] ST_P1   = P1;
    localparam logic [2:0] ST_P2   = P2;
    localparam logic [2:0] ST_P3   = P3;
    localparam logic [2:0] ST_DONE = DONE;

    logic [2:0]     state;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] acc;

    logic [H-1:0]   mul_x;
    logic [H-1:0]   mul_y;
    logic [2*H-1:0] pp;
    logic [3*H-1:0] addend;
    logic [3*H-1:0] acc_hi_sum;

    // Select the operand halves for the partial product of this state.
    always_comb begin
        mul_x = a_q[H-1:0];
        mul_y = b_q[H-1:0];
        case (state)
            ST_P1: mul_x = a_q[N-1:H];
            ST_P2: mul_y = b_q[N-1:H];
            ST_P3: begin
                mul_x = a_q[N-1:H];
                mul_y = b_q[N-1:H];
            end
            default: ;
        endcase
    end

    vedic_mult_half #(.H(H)) u_half (
        .x (mul_x),
        .y (mul_y),
        .p (pp)
    );

    // Accumulate on acc[2N-1:H]; the P3 term sits H bits further up.
    // The carry out of this 3H-bit add is dropped since a*b < 2^(2N).
    always_comb begin
        addend     = (state == ST_P3) ? {pp, {H{1'b0}}} : {{H{1'b0}}, pp};
        acc_hi_sum = acc[2*N-1:H] + addend;
    end

    // Handshake FSM, operand capture and accumulator update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        state <= ST_P0;
                    end
                end
                ST_P0: begin
`ifdef VEDIC_ZERO_BYPASS_EN
                    if (a_q == '0 || b_q == '0) begin
                        acc   <= '0;
                        state <= ST_DONE;
                    end else begin
                        acc   <= {{N{1'b0}}, pp};
                        state <= ST_P1;
                    end
`else
                    acc   <= {{N{1'b0}}, pp};
                    state <= ST_P1;
`endif
                end
                ST_P1: begin
                    acc[2*N-1:H] <= acc_hi_sum;
                    state        <= ST_P2;
                end
                ST_P2: begin
                    acc[2*N-1:H] <= acc_hi_sum;
                    state        <= ST_P3;
                end
                ST_P3: begin
                    acc[2*N-1:H] <= acc_hi_sum;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; prod is masked outside DONE.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        prod      = out_valid ? acc : '0;
    end

endmodule

// File: tb/tb_vedic_mult16_seq.sv
// Directed bench for vedic_mult16_seq: vector table of hand-computed
// products plus reset, hold-off and streaming sequences.
module tb_vedic_mult16_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prod;

    int total = 0;
    int bad   = 0;

`ifdef VEDIC_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 4;
`endif

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] vexp;
        int          vlat;
        int          vhold;
    } vec_t;

    vec_t vecs[12];

    vedic_mult16_seq #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] texp, input int tlat, input int thold);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("pre in_ready", in_ready, 1);
        out_ready = 1'b0;
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta;
        b = ~tb_v;
        check("busy prod zero", prod, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, tlat);
        check("prod", prod, texp);
        for (int h = 0; h < thold; h++) begin
            @(posedge clk); #1;
            check("hold valid", out_valid, 1);
            check("hold prod", prod, texp);
            check("hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("consume in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after valid", out_valid, 0);
        check("after prod", prod, 0);
        check("after in_ready", in_ready, 1);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int pushed;
        int popped;

        vecs[0]  = '{16'h1234, 16'h5678, 32'h06260060, 4, 0};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4, 0};
        vecs[2]  = '{16'h00FF, 16'h0100, 32'h0000FF00, 4, 6};
        vecs[3]  = '{16'h0000, 16'hBEEF, 32'h00000000, ZLAT, 0};
        vecs[4]  = '{16'hBEEF, 16'h0000, 32'h00000000, ZLAT, 2};
        vecs[5]  = '{16'h0001, 16'h0001, 32'h00000001, 4, 0};
        vecs[6]  = '{16'h8000, 16'h0002, 32'h00010000, 4, 0};
        vecs[7]  = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 4, 0};
        vecs[8]  = '{16'h0100, 16'h0100, 32'h00010000, 4, 0};
        vecs[9]  = '{16'h00FF, 16'h00FF, 32'h0000FE01, 4, 1};
        vecs[10] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001, 4, 0};
        vecs[11] = '{16'h0003, 16'h0005, 32'h0000000F, 4, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset prod", prod, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, vecs[i].vlat, vecs[i].vhold);
        end

        // reset mid-multiply (in P2) discards the operation
        a = 16'hABCD;
        b = 16'h1357;
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst out_valid", out_valid, 0);
        check("midrst prod", prod, 0);
        check("midrst in_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("midrst no result", out_valid, 0);
        end
        out_ready = 1'b0;
        run_op(16'h0003, 16'h0005, 32'h0000000F, 4, 0);

        // reset wins over a simultaneous accept
        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'h0007;
        b = 16'h0009;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst vs accept in_ready", in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        check("rst vs accept no result", out_valid, 0);

        // streaming in_valid with fresh operands every cycle
        pushed = 0;
        popped = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream spurious", 1, 0);
                end else begin
                    check("stream prod", prod, exp_q.pop_front());
                    popped++;
                end
            end
            if (in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                pushed++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream spurious", 1, 0);
                end else begin
                    check("stream prod", prod, exp_q.pop_front());
                    popped++;
                end
            end
            @(posedge clk); #1;
        end
        check("stream accepts", pushed, 10);
        check("stream drained", popped, pushed);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
